div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 85 ++++++++
 tb/tb_div_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the multi-cycle divider: FSM encoding, step count
// and the conditional two's-complement helper used for sign handling.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int         DIV_CYCLES   = 32;
    localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_CYCLES);

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// 33 pipeline-stall cycles per operation, result in {HI=remainder, LO=quotient}.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        int_flush,
    output logic        int_div_stall,
    output logic        div_finish,
    output logic [63:0] hilo_out
);

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [63:0] rq_q, rq_d;        // {partial remainder, dividend/quotient}
    logic [31:0] divisor_q;
    logic        q_sign_q, r_sign_q;
    logic [63:0] hilo_q, hilo_d;
    logic [32:0] diff;
    logic        a_neg, b_neg;

    assign a_neg = div_signed & div_a[31];
    assign b_neg = div_signed & div_b[31];

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rq_d   = {rq_q[62:0], 1'b0};
        diff   = rq_q[63:31] - {1'b0, divisor_q};
        // A clear bit 32 means the shifted remainder was >= divisor: keep the difference.
        if (!diff[32]) begin
            rq_d = {diff[31:0], rq_q[30:0], 1'b1};
        end
        hilo_d = {cond_neg(rq_d[63:32], r_sign_q), cond_neg(rq_d[31:0], q_sign_q)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rq_q      <= '0;
            divisor_q <= '0;
            q_sign_q  <= 1'b0;
            r_sign_q  <= 1'b0;
            hilo_q    <= '0;
        end else if (int_flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        rq_q      <= {32'h0, cond_neg(div_a, a_neg)};
                        divisor_q <= cond_neg(div_b, b_neg);
                        // Divide-by-zero keeps LO all ones regardless of operand signs.
                        q_sign_q  <= (a_neg ^ b_neg) & (div_b != 32'h0);
                        r_sign_q  <= a_neg;
                        cnt_q     <= DIV_CNT_INIT;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    rq_q  <= rq_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hilo_q  <= hilo_d;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_div_stall = !reset && !int_flush &&
                           ((state_q == IDLE && div_start) || state_q == CALC);
    assign div_finish    = !reset && !int_flush && (state_q == DONE);
    assign hilo_out      = hilo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner vectors, flush/reset aborts,
// back-to-back timing and randomized operands against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] div_a = '0;
    logic [31:0] div_b = '0;
    logic        int_flush = 1'b0;
    logic        int_div_stall;
    logic        div_finish;
    logic [63:0] hilo_out;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    div_unit dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_a        (div_a),
        .div_b        (div_b),
        .int_flush    (int_flush),
        .int_div_stall(int_div_stall),
        .div_finish   (div_finish),
        .hilo_out     (hilo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Launches one division and follows it until div_finish or a 40-cycle bound.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int fin_cyc,
                          output int stalls, output int fin_at);
        @(negedge clk);
        div_start = 1'b1; div_signed = s; div_a = a; div_b = b;
        #1;
        stalls  = int_div_stall ? 1 : 0;
        fin_cyc = -1;
        fin_at  = -1;
        res     = 'x;
        @(posedge clk); #1;
        div_start = 1'b0; div_a = $urandom; div_b = $urandom; div_signed = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (int_div_stall) stalls++;
            if (div_finish) begin
                fin_cyc = c; fin_at = cyc_cnt; res = hilo_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; div_start = 1'b1; div_a = 32'd50; div_b = 32'd5;
        #1;
        checks++; if (int_div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, expected 0", int_div_stall); end
        checks++; if (div_finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b, expected 0", div_finish); end
        repeat (3) @(negedge clk);
        checks++; if (hilo_out !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h, expected 0", hilo_out); end
        reset = 1'b0; div_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (div_finish !== 1'b0 || int_div_stall !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got finish=%b stall=%b, expected 0/0", div_finish, int_div_stall);
        end
    endtask

    task automatic test_divu_basic();
        logic [63:0] res;
        int fc, st, fa;
        do_div(1'b0, 32'd100, 32'd7, res, fc, st, fa);
        checks++; if (fc != 33) begin errors++; $display("FAIL basic_latency: got %0d, expected 33", fc); end
        checks++; if (st != 33) begin errors++; $display("FAIL basic_stalls: got %0d, expected 33", st); end
        checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL basic_result: got %h, expected 000000020000000e", res); end
        repeat (3) @(negedge clk);
        checks++; if (hilo_out !== 64'h00000002_0000000E || div_finish !== 1'b0) begin
            errors++; $display("FAIL basic_hold: got hilo=%h finish=%b, expected 000000020000000e/0", hilo_out, div_finish);
        end
    endtask

    task automatic test_corner_vectors();
        logic        vs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] va[5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] vb[5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [63:0] ve[5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                               64'h00000000_80000000, 64'h00000005_FFFFFFFF,
                               64'hFFFFFFFB_FFFFFFFF};
        logic [63:0] res;
        int fc, st, fa;
        for (int i = 0; i < 5; i++) begin
            do_div(vs[i], va[i], vb[i], res, fc, st, fa);
            checks++; if (res !== ve[i] || fc != 33) begin
                errors++; $display("FAIL corner_%0d: got %h at cycle %0d, expected %h at cycle 33", i, res, fc, ve[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] res, prev;
        int fc, st, fa, pulses;
        do_div(1'b0, 32'd50, 32'd8, prev, fc, st, fa);
        checks++; if (prev !== 64'h00000002_00000006) begin errors++; $display("FAIL flush_setup: got %h, expected 0000000200000006", prev); end
        @(negedge clk);
        div_start = 1'b1; div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3;
        @(posedge clk); #1;
        div_start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        int_flush = 1'b1;
        #1;
        checks++; if (int_div_stall !== 1'b0 || div_finish !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: got stall=%b finish=%b, expected 0/0", int_div_stall, div_finish);
        end
        @(posedge clk); #1;
        int_flush = 1'b0;
        @(negedge clk);
        checks++; if (int_div_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b, expected 0", int_div_stall); end
        pulses = 0;
        repeat (40) begin @(negedge clk); if (div_finish) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_finish: got %0d pulses, expected 0", pulses); end
        checks++; if (hilo_out !== prev) begin errors++; $display("FAIL flush_hilo: got %h, expected %h", hilo_out, prev); end
        // Flush and start together in IDLE: nothing may start.
        @(negedge clk);
        div_start = 1'b1; int_flush = 1'b1; div_a = 32'd77; div_b = 32'd7;
        #1;
        checks++; if (int_div_stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b, expected 0", int_div_stall); end
        @(posedge clk); #1;
        div_start = 1'b0; int_flush = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (div_finish || int_div_stall) pulses++; end
        checks++; if (pulses != 0 || hilo_out !== prev) begin
            errors++; $display("FAIL flush_start_ignored: got %0d active cycles hilo=%h, expected 0 and %h", pulses, hilo_out, prev);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int fc, st, fa, pulses;
        @(negedge clk);
        div_start = 1'b1; div_signed = 1'b0; div_a = 32'hFFFF_FFFF; div_b = 32'd1;
        @(posedge clk); #1;
        div_start = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (int_div_stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b, expected 0", int_div_stall); end
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (div_finish) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_finish: got %0d pulses, expected 0", pulses); end
        checks++; if (hilo_out !== 64'h0) begin errors++; $display("FAIL midreset_hilo: got %h, expected 0", hilo_out); end
        do_div(1'b0, 32'd9, 32'd3, res, fc, st, fa);
        checks++; if (res !== 64'h00000000_00000003 || fc != 33 || st != 33) begin
            errors++; $display("FAIL midreset_next: got %h cyc=%0d stalls=%0d, expected 0000000000000003 33 33", res, fc, st);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1, r2;
        int fc1, st1, fa1, fc2, st2, fa2;
        do_div(1'b0, 32'd10, 32'd3, r1, fc1, st1, fa1);
        do_div(1'b0, 32'd20, 32'd6, r2, fc2, st2, fa2);
        checks++; if (r1 !== 64'h00000001_00000003) begin errors++; $display("FAIL b2b_first: got %h, expected 0000000100000003", r1); end
        checks++; if (r2 !== 64'h00000002_00000003) begin errors++; $display("FAIL b2b_second: got %h, expected 0000000200000003", r2); end
        checks++; if (fa2 - fa1 != 34 || fa1 < 0 || fa2 < 0) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 34", fa2 - fa1);
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [31:0] a, b;
        logic        s;
        int fc, st, fa;
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 255);
                2:       b = -$urandom_range(1, 255);
                default: b = $urandom;
            endcase
            exp = ref_div(s, a, b);
            do_div(s, a, b, res, fc, st, fa);
            checks++; if (res !== exp || fc != 33) begin
                errors++; $display("FAIL random_%0d: s=%b a=%h b=%h got %h cyc=%0d, expected %h cyc=33", i, s, a, b, res, fc, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_corner_vectors();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
